// File: rtl/brick_field_pkg.sv
// Shared types and sizing helpers for the brick playfield store.
package brick_field_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Rows 0..HARD_ROWS-1 need two hits when the two-hit plane is built in.
  localparam int unsigned HARD_ROWS = 2;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned count_w(input int unsigned cols, input int unsigned rows);
    return $clog2(cols * rows + 1);
  endfunction

endpackage

// File: rtl/brick_ram.sv
// Brick bit store: one synchronous write port, one registered read port.
// A read of an address written in the same cycle returns the old word.
module brick_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned AW    = 8
) (
  input  logic             CLK_DRV,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK_DRV) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/brick_field.sv
// Brick playfield store, renderer and hit detector for up to four walls.
// Build option BRICK_FIELD_TWO_HIT_EN adds a hard-brick plane for the top rows.
module brick_field
  import brick_field_pkg::*;
#(
  parameter int unsigned NUM_COLS    = 16,
  parameter int unsigned NUM_ROWS    = 8,
  parameter int unsigned NUM_PLAYERS = 2
) (
  input  logic                                   CLK_DRV,
  input  logic                                   RESET,
  input  logic                                   PIX_EN,
  input  logic [addr_w(NUM_COLS)-1:0]            COL,
  input  logic [addr_w(NUM_ROWS)-1:0]            ROW,
  input  logic                                   IN_FIELD,
  input  logic                                   GAP,
  input  logic [addr_w(NUM_PLAYERS)-1:0]         PLAYER,
  input  logic                                   BALL_DISPLAY,
  input  logic                                   HIT_ARM,
  input  logic                                   SET_BRICKS,
  output logic                                   BUSY,
  output logic                                   BRICK_DISPLAY,
  output logic                                   BRICK_HIT,
  output logic [addr_w(NUM_COLS)-1:0]            HIT_COL,
  output logic [addr_w(NUM_ROWS)-1:0]            HIT_ROW,
  output logic [count_w(NUM_COLS, NUM_ROWS)-1:0] BRICKS_LEFT,
  output logic                                   FIELD_CLEAR
);

  localparam int unsigned CW    = addr_w(NUM_COLS);
  localparam int unsigned RW    = addr_w(NUM_ROWS);
  localparam int unsigned PW    = addr_w(NUM_PLAYERS);
  localparam int unsigned NW    = count_w(NUM_COLS, NUM_ROWS);
  localparam int unsigned SLOTS = 32'd1 << PW;
  localparam int unsigned DEPTH = NUM_PLAYERS * NUM_ROWS * NUM_COLS;
  localparam int unsigned AW    = addr_w(DEPTH);
  localparam int unsigned TOTAL = NUM_COLS * NUM_ROWS;
`ifdef BRICK_FIELD_TWO_HIT_EN
  localparam int unsigned DW    = 2;
`else
  localparam int unsigned DW    = 1;
`endif

  state_e          state;
  logic            set_q;
  logic            armed;
  logic [PW-1:0]   fill_player;
  logic [RW-1:0]   fill_row;
  logic [CW-1:0]   fill_col;
  logic            s1_in_field;
  logic            s1_gap;
  logic [CW-1:0]   s1_col;
  logic [RW-1:0]   s1_row;
  logic [PW-1:0]   s1_player;
  logic [CW-1:0]   s2_col;
  logic [RW-1:0]   s2_row;
  logic [PW-1:0]   s2_player;
  logic [NW-1:0]   count_q [SLOTS];
  logic            fill_last_c;
  logic            hit_c;
  logic            hit_clears_c;
  logic            we_c;
  logic [AW-1:0]   wa_c;
  logic [AW-1:0]   ra_c;
  logic [DW-1:0]   wd_c;
  logic [DW-1:0]   fill_word_c;
  logic [DW-1:0]   rd_data;
`ifdef BRICK_FIELD_TWO_HIT_EN
  logic            s2_hard;
`endif

  // Wall-major, then row-major linear address into the bit store.
  function automatic logic [AW-1:0] mem_addr(input logic [PW-1:0] p,
                                             input logic [RW-1:0] r,
                                             input logic [CW-1:0] c);
    return AW'((32'(p) * NUM_ROWS + 32'(r)) * NUM_COLS + 32'(c));
  endfunction

  assign BRICKS_LEFT = count_q[PLAYER];
  assign ra_c        = mem_addr(PLAYER, ROW, COL);
  assign fill_last_c = (fill_col == CW'(NUM_COLS - 1)) && (fill_row == RW'(NUM_ROWS - 1));
  assign hit_c       = (state == RUN) && PIX_EN && BRICK_DISPLAY && BALL_DISPLAY && armed;

`ifdef BRICK_FIELD_TWO_HIT_EN
  assign hit_clears_c = ~s2_hard;
  assign fill_word_c  = {(32'(fill_row) < HARD_ROWS), 1'b1};
`else
  assign hit_clears_c = 1'b1;
  assign fill_word_c  = 1'b1;
`endif

  // Fill owns the write port in FILL; a hit clears the stage-2 brick in RUN.
  always_comb begin
    we_c = 1'b0;
    wa_c = mem_addr(s2_player, s2_row, s2_col);
    wd_c = '0;
    if (state == FILL) begin
      we_c = 1'b1;
      wa_c = mem_addr(fill_player, fill_row, fill_col);
      wd_c = fill_word_c;
    end else if (hit_c) begin
      we_c = 1'b1;
`ifdef BRICK_FIELD_TWO_HIT_EN
      wd_c = {1'b0, s2_hard};
`endif
    end
  end

  // The registered read port doubles as the stage-1 brick bit.
  brick_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (AW)
  ) u_ram (
    .CLK_DRV (CLK_DRV),
    .we      (we_c),
    .wa      (wa_c),
    .wd      (wd_c),
    .re      (PIX_EN),
    .ra      (ra_c),
    .rd      (rd_data)
  );

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      state         <= IDLE;
      set_q         <= 1'b0;
      armed         <= 1'b0;
      BUSY          <= 1'b0;
      BRICK_DISPLAY <= 1'b0;
      BRICK_HIT     <= 1'b0;
      FIELD_CLEAR   <= 1'b0;
      HIT_COL       <= '0;
      HIT_ROW       <= '0;
      fill_player   <= '0;
      fill_row      <= '0;
      fill_col      <= '0;
      s1_in_field   <= 1'b0;
      s1_gap        <= 1'b0;
      s1_col        <= '0;
      s1_row        <= '0;
      s1_player     <= '0;
      s2_col        <= '0;
      s2_row        <= '0;
      s2_player     <= '0;
`ifdef BRICK_FIELD_TWO_HIT_EN
      s2_hard       <= 1'b0;
`endif
      for (int unsigned i = 0; i < SLOTS; i++) count_q[i] <= '0;
    end else begin
      set_q       <= SET_BRICKS;
      BRICK_HIT   <= hit_c;
      FIELD_CLEAR <= (state == RUN) && (BRICKS_LEFT == '0);

      if (PIX_EN) begin
        s1_in_field <= IN_FIELD;
        s1_gap      <= GAP;
        s1_col      <= COL;
        s1_row      <= ROW;
        s1_player   <= PLAYER;
      end

      // A hit beats a same-cycle re-arm so only one brick falls per bounce.
      if (hit_c)        armed <= 1'b0;
      else if (HIT_ARM) armed <= 1'b1;

      case (state)
        IDLE: begin
          BRICK_DISPLAY <= 1'b0;
          if (SET_BRICKS) begin
            state       <= FILL;
            BUSY        <= 1'b1;
            fill_player <= PLAYER;
            fill_row    <= '0;
            fill_col    <= '0;
          end
        end

        FILL: begin
          BRICK_DISPLAY <= 1'b0;
          if (fill_col == CW'(NUM_COLS - 1)) begin
            fill_col <= '0;
            fill_row <= fill_row + RW'(1);
          end else begin
            fill_col <= fill_col + CW'(1);
          end
          if (fill_last_c) begin
            state                <= RUN;
            BUSY                 <= 1'b0;
            armed                <= 1'b1;
            count_q[fill_player] <= NW'(TOTAL);
          end
        end

        RUN: begin
          if (PIX_EN) begin
            BRICK_DISPLAY <= rd_data[0] & s1_in_field & ~s1_gap;
            s2_col        <= s1_col;
            s2_row        <= s1_row;
            s2_player     <= s1_player;
`ifdef BRICK_FIELD_TWO_HIT_EN
            s2_hard       <= rd_data[1];
`endif
          end
          if (hit_c) begin
            HIT_COL <= s2_col;
            HIT_ROW <= s2_row;
            if (hit_clears_c && (count_q[s2_player] != '0))
              count_q[s2_player] <= count_q[s2_player] - NW'(1);
          end
          // Only a fresh request refills; a held level is ignored.
          if (SET_BRICKS && !set_q) begin
            state         <= FILL;
            BUSY          <= 1'b1;
            BRICK_DISPLAY <= 1'b0;
            fill_player   <= PLAYER;
            fill_row      <= '0;
            fill_col      <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field against a wall/count/arm reference model.
module tb_brick_field;

  localparam int unsigned NC    = 16;
  localparam int unsigned NR    = 8;
  localparam int unsigned NP    = 2;
  localparam int          TOTAL = NC * NR;
`ifdef BRICK_FIELD_TWO_HIT_EN
  localparam bit TWO_HIT = 1'b1;
`else
  localparam bit TWO_HIT = 1'b0;
`endif

  logic       CLK_DRV = 1'b0;
  logic       RESET;
  logic       PIX_EN;
  logic [3:0] COL;
  logic [2:0] ROW;
  logic       IN_FIELD;
  logic       GAP;
  logic [0:0] PLAYER;
  logic       BALL_DISPLAY;
  logic       HIT_ARM;
  logic       SET_BRICKS;
  logic       BUSY;
  logic       BRICK_DISPLAY;
  logic       BRICK_HIT;
  logic [3:0] HIT_COL;
  logic [2:0] HIT_ROW;
  logic [7:0] BRICKS_LEFT;
  logic       FIELD_CLEAR;

  brick_field #(
    .NUM_COLS    (NC),
    .NUM_ROWS    (NR),
    .NUM_PLAYERS (NP)
  ) dut (
    .CLK_DRV       (CLK_DRV),
    .RESET         (RESET),
    .PIX_EN        (PIX_EN),
    .COL           (COL),
    .ROW           (ROW),
    .IN_FIELD      (IN_FIELD),
    .GAP           (GAP),
    .PLAYER        (PLAYER),
    .BALL_DISPLAY  (BALL_DISPLAY),
    .HIT_ARM       (HIT_ARM),
    .SET_BRICKS    (SET_BRICKS),
    .BUSY          (BUSY),
    .BRICK_DISPLAY (BRICK_DISPLAY),
    .BRICK_HIT     (BRICK_HIT),
    .HIT_COL       (HIT_COL),
    .HIT_ROW       (HIT_ROW),
    .BRICKS_LEFT   (BRICKS_LEFT),
    .FIELD_CLEAR   (FIELD_CLEAR)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  // Reference model: what each wall looks like and how many bricks remain.
  bit brick_m [NP][NR][NC];
  bit hard_m  [NP][NR][NC];
  bit valid_m [NP];
  int count_m [NP];
  bit armed_m;
  int last_col_m;
  int last_row_m;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_DRV);
    #1;
  endtask

  task automatic fill_wall(input int p, input int hold);
    int n;
    PLAYER = 1'(p); SET_BRICKS = 1'b1;
    COL = '0; ROW = '0; IN_FIELD = 1'b1; GAP = 1'b0; PIX_EN = 1'b1;
    step();
    n = 0;
    while (BUSY === 1'b1 && n < 1000) begin
      check("display_in_fill", BRICK_DISPLAY, 0);
      n++;
      step();
    end
    check("busy_cycles", n, TOTAL);
    for (int i = 0; i < hold; i++) begin
      step();
      check("no_retrigger", BUSY, 0);
    end
    SET_BRICKS = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        brick_m[p][r][c] = 1'b1;
        hard_m[p][r][c]  = TWO_HIT && (r < 2);
      end
    valid_m[p] = 1'b1;
    count_m[p] = TOTAL;
    armed_m    = 1'b1;
    step();
    check("bricks_left_after_fill", BRICKS_LEFT, count_m[p]);
  endtask

  task automatic scan_at(input int p, input int c, input int r, input bit inf,
                         input bit gp, input bit gappy);
    int q;
    int guard;
    bit exp;
    PLAYER = 1'(p); COL = 4'(c); ROW = 3'(r); IN_FIELD = inf; GAP = gp;
    BALL_DISPLAY = 1'b0;
    if (!gappy) begin
      PIX_EN = 1'b1;
      step();
      step();
    end else begin
      q = 0;
      guard = 0;
      while (q < 2 && guard < 64) begin
        PIX_EN = 1'($urandom_range(0, 1));
        step();
        if (PIX_EN) q++;
        guard++;
      end
      check("pix_en_budget", q, 2);
    end
    exp = valid_m[p] && brick_m[p][r][c] && inf && !gp;
    if (valid_m[p]) check("display", BRICK_DISPLAY, exp);
    if (gappy && valid_m[p]) begin
      PIX_EN = 1'b0;
      step();
      step();
      check("display_hold", BRICK_DISPLAY, exp);
    end
    PIX_EN = 1'b1;
  endtask

  task automatic hit_at(input int p, input int c, input int r, input bit arm_too);
    bit exp_hit;
    scan_at(p, c, r, 1'b1, 1'b0, 1'b0);
    exp_hit = armed_m && valid_m[p] && brick_m[p][r][c];
    BALL_DISPLAY = 1'b1;
    HIT_ARM = arm_too;
    step();
    BALL_DISPLAY = 1'b0;
    HIT_ARM = 1'b0;
    check("hit_pulse", BRICK_HIT, exp_hit);
    if (exp_hit) begin
      last_col_m = c;
      last_row_m = r;
      armed_m = 1'b0;
      if (hard_m[p][r][c]) begin
        hard_m[p][r][c] = 1'b0;
      end else begin
        brick_m[p][r][c] = 1'b0;
        count_m[p] = (count_m[p] > 0) ? count_m[p] - 1 : 0;
      end
    end else if (arm_too) begin
      armed_m = 1'b1;
    end
    check("hit_col", HIT_COL, last_col_m);
    check("hit_row", HIT_ROW, last_row_m);
    step();
    check("hit_one_cycle", BRICK_HIT, 0);
    check("bricks_left", BRICKS_LEFT, count_m[p]);
  endtask

  task automatic arm();
    HIT_ARM = 1'b1;
    step();
    HIT_ARM = 1'b0;
    armed_m = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int op;
    RESET = 1'b1; PIX_EN = 1'b0; COL = '0; ROW = '0; IN_FIELD = 1'b0; GAP = 1'b0;
    PLAYER = '0; BALL_DISPLAY = 1'b0; HIT_ARM = 1'b0; SET_BRICKS = 1'b0;
    for (int i = 0; i < NP; i++) begin
      valid_m[i] = 1'b0;
      count_m[i] = 0;
    end
    armed_m = 1'b0;
    last_col_m = 0;
    last_row_m = 0;

    step(); step(); step();
    check("rst_busy", BUSY, 0);
    check("rst_display", BRICK_DISPLAY, 0);
    check("rst_hit", BRICK_HIT, 0);
    check("rst_field_clear", FIELD_CLEAR, 0);
    check("rst_hit_col", HIT_COL, 0);
    check("rst_hit_row", HIT_ROW, 0);
    check("rst_bricks_left", BRICKS_LEFT, 0);
    RESET = 1'b0;
    step();
    check("idle_busy", BUSY, 0);

    // Fill wall 0 with SET_BRICKS held past completion.
    fill_wall(0, 5);

    // Two-cycle render latency at (3,2).
    PLAYER = 1'b0; COL = 4'd3; ROW = 3'd2; IN_FIELD = 1'b0; GAP = 1'b0; PIX_EN = 1'b1;
    step(); step();
    check("latency_pre", BRICK_DISPLAY, 0);
    IN_FIELD = 1'b1;
    step();
    check("latency_1", BRICK_DISPLAY, 0);
    step();
    check("latency_2", BRICK_DISPLAY, 1);
    check("field_not_clear", FIELD_CLEAR, 0);

    // Hit at (5,1), brick goes dark, second overlap needs a re-arm.
    hit_at(0, 5, 1, 1'b0);
    scan_at(0, 5, 1, 1'b1, 1'b0, 1'b0);
    hit_at(0, 6, 1, 1'b0);
    arm();
    hit_at(0, 6, 1, 1'b0);
    scan_at(0, 7, 7, 1'b1, 1'b1, 1'b0);

    // Wall isolation between players.
    fill_wall(0, 0);
    fill_wall(1, 0);
    hit_at(1, 0, 0, 1'b0);
    scan_at(0, 0, 0, 1'b1, 1'b0, 1'b0);
    PLAYER = 1'b0;
    step();
    check("p0_count", BRICKS_LEFT, count_m[0]);
    PLAYER = 1'b1;
    step();
    check("p1_count", BRICKS_LEFT, count_m[1]);

    // Hit and re-arm in the same cycle leaves the detector disarmed.
    arm();
    hit_at(1, 3, 3, 1'b1);
    hit_at(1, 4, 3, 1'b0);

    // Brick (2,0) hit twice.
    arm();
    hit_at(0, 2, 0, 1'b0);
    arm();
    hit_at(0, 2, 0, 1'b0);

    // Reset 40 cycles into a fill.
    PLAYER = 1'b0; SET_BRICKS = 1'b1;
    step();
    for (int i = 0; i < 39; i++) step();
    check("mid_fill_busy", BUSY, 1);
    RESET = 1'b1; SET_BRICKS = 1'b0;
    step();
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_display", BRICK_DISPLAY, 0);
    check("mid_rst_bricks_left", BRICKS_LEFT, 0);
    check("mid_rst_hit_col", HIT_COL, 0);
    RESET = 1'b0;
    for (int i = 0; i < NP; i++) count_m[i] = 0;
    valid_m[0] = 1'b0;
    armed_m = 1'b0;
    last_col_m = 0;
    last_row_m = 0;
    step();
    check("post_rst_busy", BUSY, 0);
    fill_wall(0, 0);
    fill_wall(1, 0);

    // Randomised scans, hits and re-arms against the model.
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 5));
      p  = int'($urandom_range(0, NP - 1));
      case (op)
        0, 1: scan_at(p, int'($urandom_range(0, NC - 1)), int'($urandom_range(0, NR - 1)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), (op == 1));
        2, 3: hit_at(p, int'($urandom_range(0, NC - 1)), int'($urandom_range(0, NR - 1)),
                     ($urandom_range(0, 3) == 0));
        4: arm();
        default: begin
          PLAYER = 1'(p);
          step();
          step();
          check("rand_bricks_left", BRICKS_LEFT, count_m[p]);
          check("rand_field_clear", FIELD_CLEAR, (count_m[p] == 0));
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/brick_field.md
Name: brick_field

Overview:
- Parametrised brick playfield store and hit detector; successor to the fixed 8x8, two-player brick logic.
- Holds one bit per brick per player.
- Bulk-fills a player's wall on request, renders bricks from beam position, clears a brick on ball contact, and tracks remaining bricks.
- Sits between the sync/counter chain and the video mixer / score logic.

Parameters:
- NUM_COLS, 16, bricks per row; power of two, 4..64.
- NUM_ROWS, 8, brick rows; 1..32.
- NUM_PLAYERS, 2, independent walls; 1..4.

Ports:
- CLK_DRV  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PIX_EN  in  1  pixel strobe; the beam pipeline advances only when high.
- COL  in  $clog2(NUM_COLS)  brick column under beam.
- ROW  in  $clog2(NUM_ROWS)  brick row under beam.
- IN_FIELD  in  1  beam inside brick area.
- GAP  in  1  mortar pixel; forces display low (e.g. 1H&2H).
- PLAYER  in  $clog2(NUM_PLAYERS) (min 1)  active wall.
- BALL_DISPLAY  in  1  ball pixel, aligned to the BRICK_DISPLAY stage.
- HIT_ARM  in  1  paddle/top-wall bounce; re-arms hit detection.
- SET_BRICKS  in  1  level; request to refill the wall of PLAYER.
- BUSY  out  1  fill in progress.
- BRICK_DISPLAY  out  1  brick video.
- BRICK_HIT  out  1  one-cycle hit pulse.
- HIT_COL / HIT_ROW  out  COL/ROW widths  address of the last brick hit.
- BRICKS_LEFT  out  $clog2(NUM_COLS*NUM_ROWS+1)  remaining bricks of PLAYER.
- FIELD_CLEAR  out  1  BRICKS_LEFT==0 while in RUN.

Behaviour:
- Reset: state IDLE. BUSY, BRICK_DISPLAY, BRICK_HIT, FIELD_CLEAR = 0. HIT_COL, HIT_ROW = 0. All per-player counts = 0. armed = 0.
- Reset does not clear the memory array. A reset mid-fill abandons the fill; the wall contents are then don't-care until the next fill.
- States: IDLE, FILL, RUN.
  - IDLE -> FILL on SET_BRICKS.
  - FILL -> RUN after the last address is written.
  - RUN -> FILL on a rising edge of SET_BRICKS.
- FILL:
  - Latch PLAYER at entry.
  - Write 1 to one address per clock, row-major from (0,0); PIX_EN is ignored.
  - Takes NUM_COLS*NUM_ROWS cycles; BUSY is high throughout.
  - On exit: count[player] = NUM_COLS*NUM_ROWS, armed = 1.
- Display path (RUN only, advances on PIX_EN):
  - Stage 1 registers COL, ROW, IN_FIELD, GAP.
  - BRICK_DISPLAY = mem[PLAYER][stage1 addr] & IN_FIELD & ~GAP, registered.
  - Latency: 2 PIX_EN-qualified cycles from inputs to BRICK_DISPLAY.
  - BRICK_DISPLAY is 0 in IDLE and FILL.
- Hit:
  - Condition: RUN & PIX_EN & BRICK_DISPLAY & BALL_DISPLAY & armed.
  - Next cycle: clear the stage-2 address bit, BRICK_HIT = 1 for exactly one clock, HIT_COL/HIT_ROW updated, count[PLAYER] decremented, armed = 0.
  - At most one hit per arm.
  - Hit and HIT_ARM in the same cycle: hit wins, armed ends at 0.
  - HIT_ARM alone: armed = 1.
- The count never wraps below 0. A hit on a count of 0 is impossible because the bit is already clear.
- PLAYER change takes effect at the next stage-1 register; BRICKS_LEFT selects the count combinationally from PLAYER.
- SET_BRICKS held high after FILL completes does not retrigger; retriggering requires a low-to-high edge.
- Memory: NUM_PLAYERS*NUM_ROWS*NUM_COLS bits, one read port and one write port. A write and a read of the same address in the same cycle returns the old data.

Optional Feature:
- Macro: BRICK_FIELD_TWO_HIT_EN.
- Defined:
  - A second bit plane marks rows 0..1 as "hard".
  - The first hit on a hard brick clears only the hard bit: BRICK_HIT pulses, the count is unchanged.
  - The second hit clears the brick and decrements the count.
  - FILL sets both planes.
- Undefined: no second plane, and every hit clears the brick.

Decomposition:
- Package brick_field_pkg holds:
  - state enum (IDLE, FILL, RUN);
  - width functions for address and count;
  - the HARD_ROWS constant (2).
- One sub-module, brick_ram: parametrised 1-bit (or 2-bit with the feature) synchronous-write array with a registered read.

Test Plan:
- Fill then render: reset, SET_BRICKS=1, PLAYER=0 with defaults -> BUSY high for exactly 128 cycles, then BRICKS_LEFT=128. Scanning COL=3, ROW=2, IN_FIELD=1, GAP=0 gives BRICK_DISPLAY=1 two PIX_EN later.
- Hit: after fill, BALL_DISPLAY aligned with display at (5,1) -> one BRICK_HIT pulse, HIT_COL=5, HIT_ROW=1, BRICKS_LEFT=127, and the brick is dark on the next scan. A second overlap before HIT_ARM gives no pulse.
- Player isolation: fill P0 and P1, hit (0,0) on P1 -> P0 still shows (0,0), P0 count=128, P1 count=127.
- Simultaneous: hit and HIT_ARM in the same cycle -> armed=0, and the next overlap does not hit.
- Reset mid-fill at cycle 40 -> IDLE, BUSY=0, BRICK_DISPLAY=0. A new fill completes with count 128.
- Two-hit (with the macro): two hits on (2,0) -> two pulses, count 128 -> 127 only after the second.
